// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: multiplexed 7-segment display driver.
//
// A prescaler issues one SCAN_CE pulse per digit slot. SCAN_CE advances an
// external circulating-zero ring counter whose state comes back on DIG_SEL.
// The driver decodes the selected digit from shadow registers. The shadow
// registers are only refreshed at a frame boundary, so a digit never tears
// mid-frame.
//
// Ports:
//   CLK, CLR    clock, synchronous active-high reset
//   SCAN_CE     one-cycle digit-advance pulse (CE of the ring counter)
//   DIG_SEL     active-low one-hot digit select from the ring counter
//   BCD         4 bits per digit, digit i at BCD[4i+3:4i]
//   DP          decimal-point request per digit (active-high)
//   BLINK_MASK  digits that blink (active-high)
//   LZ_EN       leading-zero suppression enable
//   UPD         request to load BCD/DP/BLINK_MASK/LZ_EN at the next frame end
//   UPD_ACK     one-cycle pulse after the shadow load
//   AN          anode drive, active-low
//   SEG         segments {g,f,e,d,c,b,a}, active-low
//   SEG_DP      decimal point, active-low
module seg7_scan_drv #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                CLK,
  input  logic                CLR,
  output logic                SCAN_CE,
  input  logic [DIGITS-1:0]   DIG_SEL,
  input  logic [4*DIGITS-1:0] BCD,
  input  logic [DIGITS-1:0]   DP,
  input  logic [DIGITS-1:0]   BLINK_MASK,
  input  logic                LZ_EN,
  input  logic                UPD,
  output logic                UPD_ACK,
  output logic [DIGITS-1:0]   AN,
  output logic [6:0]          SEG,
  output logic                SEG_DP
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]       presc_reg, presc_next;
  logic                scan_ce_reg, scan_ce_next;
  logic [DW-1:0]       dead_reg, dead_next;
  logic [FW-1:0]       frame_reg;
  logic                phase_reg;
  logic                pend_reg;
  logic                ack_reg;
  logic [4*DIGITS-1:0] bcd_sh_reg;
  logic [DIGITS-1:0]   dp_sh_reg, blink_sh_reg;
  logic                lz_sh_reg;
  logic [DIGITS-1:0]   an_reg, an_next;
  logic [6:0]          seg_reg, seg_next;
  logic                seg_dp_reg, seg_dp_next;

  logic                frame_end, load;
  logic [DIGITS-1:0]   sel_low;
  logic                sel_valid;
  logic [IW-1:0]       sel_idx;
  logic [3:0]          code [DIGITS];
  logic [DIGITS-1:0]   blink_vec, blank_vec;
  logic                zero_run;
  logic [3:0]          cur_code;
  logic                cur_blank, cur_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    case (c)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;  // non-BCD codes show a dash
    endcase
  endfunction

  // Timing: SCAN_CE is registered off presc_next so that it is high in the
  // same cycle the count sits at PRESCALE-1.
  always_comb begin
    presc_next   = (presc_reg == PW'(PRESCALE - 1)) ? '0 : presc_reg + PW'(1);
    scan_ce_next = (presc_next == PW'(PRESCALE - 1));
    if (scan_ce_reg)
      dead_next = DW'(BLANK_CYCLES);
    else if (dead_reg != '0)
      dead_next = dead_reg - DW'(1);
    else
      dead_next = '0;
    frame_end = scan_ce_reg && !DIG_SEL[DIGITS-1];
    load      = frame_end && pend_reg;
  end

  // Digit select: valid only when exactly one bit of DIG_SEL is low.
  always_comb begin
    sel_low   = ~DIG_SEL;
    sel_valid = (sel_low != '0) && ((sel_low & (sel_low - DIGITS'(1))) == '0);
    sel_idx   = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel_low[i]) sel_idx = IW'(i);
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign code[gi]      = bcd_sh_reg[4*gi +: 4];
    assign blink_vec[gi] = phase_reg && blink_sh_reg[gi];
  end

  // Leading-zero run is scanned from the most significant digit downwards;
  // digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = blink_vec;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (code[i] == 4'd0);
      if (lz_sh_reg && zero_run) blank_vec[i] = 1'b1;
    end
  end

  always_comb begin
    cur_code  = code[sel_idx];
    cur_blank = blank_vec[sel_idx];
    cur_dp    = dp_sh_reg[sel_idx];
    // Anodes go dark while the dead-time counter is (about to be) nonzero so
    // the previous digit's segments never ghost onto the new anode.
    an_next   = (!sel_valid || dead_next != '0) ? '1 : DIG_SEL;
    if (!sel_valid || cur_blank) begin
      seg_next    = 7'h7F;
      seg_dp_next = 1'b1;
    end else begin
      seg_next    = seg_decode(cur_code);
      seg_dp_next = ~cur_dp;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      presc_reg    <= '0;
      scan_ce_reg  <= 1'b0;
      dead_reg     <= '0;
      frame_reg    <= '0;
      phase_reg    <= 1'b0;
      pend_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      bcd_sh_reg   <= '0;
      dp_sh_reg    <= '0;
      blink_sh_reg <= '0;
      lz_sh_reg    <= 1'b0;
      an_reg       <= '1;
      seg_reg      <= 7'h7F;
      seg_dp_reg   <= 1'b1;
    end else begin
      presc_reg   <= presc_next;
      scan_ce_reg <= scan_ce_next;
      dead_reg    <= dead_next;
      ack_reg     <= load;
      if (frame_end) begin
        if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
          frame_reg <= '0;
          phase_reg <= ~phase_reg;
        end else begin
          frame_reg <= frame_reg + FW'(1);
        end
      end
      // A request arriving in the load cycle itself re-arms the flag.
      if (load) begin
        bcd_sh_reg   <= BCD;
        dp_sh_reg    <= DP;
        blink_sh_reg <= BLINK_MASK;
        lz_sh_reg    <= LZ_EN;
        pend_reg     <= UPD;
      end else if (UPD) begin
        pend_reg <= 1'b1;
      end
      an_reg     <= an_next;
      seg_reg    <= seg_next;
      seg_dp_reg <= seg_dp_next;
    end
  end

  assign SCAN_CE = scan_ce_reg;
  assign UPD_ACK = ack_reg;
  assign AN      = an_reg;
  assign SEG     = seg_reg;
  assign SEG_DP  = seg_dp_reg;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Testbench for seg7_scan_drv with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2. A circulating-zero ring counter clocked by SCAN_CE closes
// the loop. Every cycle is checked against a cycle-count based reference
// model. Table vectors and hand sequences cover the display corner cases.
module tb_seg7_scan_drv;
  localparam int P  = 8;
  localparam int BL = 2;
  localparam int BF = 2;
  localparam int D  = 4;

  logic        CLK, CLR, scan_ce, upd, upd_ack, lz, seg_dp;
  logic [3:0]  dig_sel, dp, blink, an;
  logic [15:0] bcd;
  logic [6:0]  seg;

  seg7_scan_drv #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut (
    .CLK(CLK), .CLR(CLR), .SCAN_CE(scan_ce), .DIG_SEL(dig_sel), .BCD(bcd), .DP(dp),
    .BLINK_MASK(blink), .LZ_EN(lz), .UPD(upd), .UPD_ACK(upd_ack), .AN(an), .SEG(seg),
    .SEG_DP(seg_dp)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release, frame ends seen,
  // pending request and the shadow contents.
  int          k;
  int          frames_m;
  logic        pend_m;
  logic [15:0] sh_bcd;
  logic [3:0]  sh_dp, sh_blink;
  logic        sh_lz;
  logic [3:0]  ring;
  logic        force_sel;
  logic [6:0]  seg_lut [16];

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpo;   // expected SEG_DP per digit
  } vec_t;
  vec_t vecs [7];

  function automatic vec_t mk(string n, logic [15:0] b, logic [3:0] p, logic l,
                              logic [27:0] s, logic [3:0] o);
    vec_t v;
    v.name = n; v.bcd = b; v.dp = p; v.lz = l; v.seg = s; v.dpo = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // One clock: predict outputs for the coming edge, advance the model,
  // clock, update the ring counter, compare.
  task automatic step();
    int zc, d, top, e;
    logic valid, phase, blank_d, dead, pre_ce, fe, ld, ce_before;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic exp_sdp;
    zc = 0; d = 0; top = -1;
    for (int i = 0; i < D; i++) if (!dig_sel[i]) begin zc++; d = i; end
    valid = (zc == 1);
    for (int i = 0; i < D; i++) if (sh_bcd[4*i +: 4] != 4'd0) top = i;
    phase   = ((frames_m / BF) % 2) == 1;
    blank_d = (sh_lz && d != 0 && d > top) || (phase && sh_blink[d]);
    e       = k + 1;
    dead    = (e >= P) && ((e % P) < BL);
    exp_an  = (!valid || dead) ? 4'hF : dig_sel;
    exp_seg = (!valid || blank_d) ? 7'h7F : seg_lut[sh_bcd[4*d +: 4]];
    exp_sdp = !(valid && !blank_d && sh_dp[d]);
    pre_ce  = (k % P) == (P - 1);
    fe      = pre_ce && !dig_sel[D-1];
    ld      = fe && pend_m;
    if (fe) frames_m++;
    if (ld) begin
      sh_bcd = bcd; sh_dp = dp; sh_blink = blink; sh_lz = lz; pend_m = upd;
    end else if (upd) begin
      pend_m = 1'b1;
    end
    ce_before = scan_ce;
    @(posedge CLK); #1;
    k++;
    if (ce_before === 1'b1) ring = (ring == 4'hF) ? 4'hE : {ring[2:0], ring[3]};
    dig_sel = force_sel ? 4'($urandom_range(0, 15)) : ring;
    chk("scan_ce", 32'(scan_ce), 32'((k % P) == (P - 1)));
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("seg_dp", 32'(seg_dp), 32'(exp_sdp));
    chk("upd_ack", 32'(upd_ack), 32'(ld));
  endtask

  task automatic reset_dut(input int n);
    CLR = 1'b1; upd = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      ring = 4'hF; dig_sel = 4'hF;
      chk("rst_scan_ce", 32'(scan_ce), 0);
      chk("rst_upd_ack", 32'(upd_ack), 0);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_seg_dp", 32'(seg_dp), 1);
    end
    CLR = 1'b0;
    k = 0; frames_m = 0; pend_m = 1'b0;
    sh_bcd = '0; sh_dp = '0; sh_blink = '0; sh_lz = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!(scan_ce === 1'b1 && dig_sel[D-1] == 1'b0) && n < 100) begin step(); n++; end
    chk("frame_wait", 32'(n < 100), 1);
  endtask

  task automatic load(input logic [15:0] b, input logic [3:0] p, input logic [3:0] m,
                      input logic l);
    int n = 0;
    bcd = b; dp = p; blink = m; lz = l; upd = 1'b1;
    step();
    upd = 1'b0;
    while (upd_ack !== 1'b1 && n < 200) begin step(); n++; end
    chk("ack_wait", 32'(n < 200), 1);
  endtask

  // Capture one whole frame (digits 0..3) starting at a frame end.
  task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dps);
    logic [3:0] m;
    segs = 'x; dps = 'x;
    wait_frame();
    repeat (P * D) begin
      step();
      for (int d = 0; d < D; d++) begin
        m = 4'b0001 << d;
        if (an == ~m) begin segs[7*d +: 7] = seg; dps[d] = seg_dp; end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] segs;
    logic [3:0]  dps;
    logic        vis [8];
    int          n, acks;

    seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001; seg_lut[2] = 7'b0100100;
    seg_lut[3] = 7'b0110000; seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
    seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000; seg_lut[8] = 7'b0000000;
    seg_lut[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_lut[i] = 7'b0111111;

    vecs[0] = mk("1234", 16'h1234, 4'b0000, 1'b0,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111);
    vecs[1] = mk("0070_lz", 16'h0070, 4'b0000, 1'b1,
                 {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'b1111);
    vecs[2] = mk("0000_lz", 16'h0000, 4'b1110, 1'b1,
                 {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111);
    vecs[3] = mk("0B00_dp", 16'h0B00, 4'b0100, 1'b0,
                 {7'b1000000, 7'b0111111, 7'b1000000, 7'b1000000}, 4'b1011);
    vecs[4] = mk("5678_dp", 16'h5678, 4'b1111, 1'b1,
                 {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b0000);
    vecs[5] = mk("0901_lz", 16'h0901, 4'b1001, 1'b1,
                 {7'h7F, 7'b0010000, 7'b1000000, 7'b1111001}, 4'b1110);
    vecs[6] = mk("FE0C", 16'hFE0C, 4'b0000, 1'b1,
                 {7'b0111111, 7'b0111111, 7'b1000000, 7'b0111111}, 4'b1111);

    CLK = 1'b0; CLR = 1'b1; upd = 1'b0; bcd = '0; dp = '0; blink = '0; lz = 1'b0;
    force_sel = 1'b0; ring = 4'hF; dig_sel = 4'hF; k = 0;
    reset_dut(3);
    $display("reset: outputs idle");

    // First visible anode: the first slot minus its dead time.
    n = 0;
    while (an == 4'hF && n < 40) begin step(); n++; end
    chk("first_an_k", 32'(k), 32'(P + BL));
    chk("first_an", 32'(an), 32'hE);
    $display("startup: first anode at edge %0d", k);

    foreach (vecs[i]) begin
      load(vecs[i].bcd, vecs[i].dp, 4'b0000, vecs[i].lz);
      capture_frame(segs, dps);
      chk({vecs[i].name, "_seg"}, 32'(segs), 32'(vecs[i].seg));
      chk({vecs[i].name, "_dp"}, 32'(dps), 32'(vecs[i].dpo));
      $display("vector %s: bcd=%h segs=%h dps=%b", vecs[i].name, vecs[i].bcd, segs, dps);
    end

    // Input changes without UPD must not reach the display.
    load(vecs[3].bcd, vecs[3].dp, 4'b0000, vecs[3].lz);
    bcd = 16'h1234; dp = 4'b0000; lz = 1'b1; blink = 4'b1111;
    capture_frame(segs, dps);
    chk("no_upd_seg", 32'(segs), 32'(vecs[3].seg));
    chk("no_upd_dp", 32'(dps), 32'(vecs[3].dpo));
    $display("no-update: segs=%h dps=%b", segs, dps);

    // Blink digit 0: visibility alternates with a two-frame half period.
    load(16'h1234, 4'b0000, 4'b0001, 1'b0);
    for (int f = 0; f < 8; f++) begin
      capture_frame(segs, dps);
      vis[f] = (segs[6:0] != 7'h7F);
      chk("blink_other", 32'(segs[27:7]), 32'({7'b1111001, 7'b0100100, 7'b0110000}));
    end
    for (int f = 0; f < 6; f++) chk("blink_alt", 32'(vis[f] ^ vis[f+2]), 1);
    $display("blink: digit0 visibility %b%b%b%b%b%b%b%b",
             vis[0], vis[1], vis[2], vis[3], vis[4], vis[5], vis[6], vis[7]);

    // Reset while an update is pending discards it.
    load(16'h5678, 4'b0000, 4'b0000, 1'b0);
    wait_frame();
    bcd = 16'h9999; upd = 1'b1;
    step();
    upd = 1'b0;
    repeat (5) step();
    reset_dut(1);
    acks = 0;
    repeat (3 * P * D + 40) begin
      step();
      if (upd_ack === 1'b1) acks++;
    end
    chk("clr_no_ack", 32'(acks), 0);
    $display("clear-pending: acks after reset=%0d", acks);

    // Randomized inputs and update requests.
    for (int i = 0; i < 1500; i++) begin
      bcd = 16'($urandom); dp = 4'($urandom); blink = 4'($urandom);
      lz = 1'($urandom); upd = ($urandom_range(0, 15) == 0);
      step();
      if (upd_ack === 1'b1) $display("random: load acknowledged at edge %0d", k);
    end
    upd = 1'b0;

    // Arbitrary DIG_SEL patterns, including invalid ones.
    force_sel = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bcd = 16'($urandom); lz = 1'($urandom); upd = ($urandom_range(0, 7) == 0);
      step();
    end
    upd = 1'b0; force_sel = 1'b0;
    repeat (P * D) step();
    $display("random: done at edge %0d", k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
